// File: rtl/vx_smem_bank_unit.sv
// Banked shared-memory stage: splits a multi-lane batch across single-port SRAM banks.
// Define SMEM_READ_BCAST_EN to let same-row reads share a bank read in one cycle.
module vx_smem_bank_unit #(
    parameter int LANES      = 4,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_WORDS = 256,
    parameter int DATA_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [LANES-1:0]                req_valid,
    input  logic [LANES-1:0]                req_rw,
    input  logic [LANES*DATA_SIZE-1:0]      req_byteen,
    input  logic [LANES*ADDR_WIDTH-1:0]     req_addr,
    input  logic [LANES*8*DATA_SIZE-1:0]    req_data,
    input  logic [LANES*TAG_WIDTH-1:0]      req_tag,
    output logic [LANES-1:0]                req_ready,
    output logic                            rsp_valid,
    output logic [LANES-1:0]                rsp_tmask,
    output logic [LANES*8*DATA_SIZE-1:0]    rsp_data,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    input  logic                            rsp_ready
);

    localparam int DW         = 8 * DATA_SIZE;
    localparam int WORD_SHIFT = $clog2(DATA_SIZE);
    localparam int BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROW_BITS   = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

`ifdef SMEM_READ_BCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RSP} state_t;

    state_t                          r_state;
    logic [LANES-1:0]                r_pending;
    logic [LANES-1:0]                r_tmask;
    logic [LANES-1:0]                r_isRead;
    logic [LANES-1:0]                r_rw;
    logic [LANES-1:0]                r_rdGrant;
    logic [LANES*DATA_SIZE-1:0]      r_byteen;
    logic [LANES*ADDR_WIDTH-1:0]     r_addr;
    logic [LANES*DW-1:0]             r_data;
    logic [TAG_WIDTH-1:0]            r_tag;
    logic [LANES-1:0][DW-1:0]        r_result;
    logic                            r_rspValid;
    logic [LANES-1:0]                r_rspTmask;
    logic [LANES*DW-1:0]             r_rspData;
    logic [TAG_WIDTH-1:0]            r_rspTag;

    logic [DW-1:0]                   r_mem [NUM_BANKS][BANK_WORDS];
    logic [DW-1:0]                   r_bankRdata [NUM_BANKS];

    logic [BANK_BITS-1:0]            w_bank [LANES];
    logic [ROW_BITS-1:0]             w_row [LANES];
    logic [LANES-1:0]                w_grant;
    logic [NUM_BANKS-1:0]            w_bankEn;
    logic [NUM_BANKS-1:0]            w_bankWe;
    logic [NUM_BANKS-1:0]            w_bankRead;
    logic [NUM_BANKS-1:0]            w_bankWrSeen;
    logic [ROW_BITS-1:0]             w_bankRow [NUM_BANKS];
    logic [DATA_SIZE-1:0]            w_bankByteen [NUM_BANKS];
    logic [DW-1:0]                   w_bankWdata [NUM_BANKS];
    logic [TAG_WIDTH-1:0]            w_firstTag;
    logic                            w_unused;

    assign w_unused  = ^r_addr;
    assign req_ready = {LANES{(r_state == IDLE) && reset}};
    assign rsp_valid = r_rspValid;
    assign rsp_tmask = r_rspTmask;
    assign rsp_data  = r_rspData;
    assign rsp_tag   = r_rspTag;

    // Upper address bits beyond the row field are dropped, so addresses wrap.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_bank[l] = r_addr[l*ADDR_WIDTH + WORD_SHIFT +: BANK_BITS];
            w_row[l]  = r_addr[l*ADDR_WIDTH + WORD_SHIFT + BANK_BITS +: ROW_BITS];
        end
    end

    always_comb begin
        w_firstTag = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (req_valid[l]) w_firstTag = req_tag[l*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    // Walking lanes upward gives each bank to its lowest pending lane, which preserves lane order.
    always_comb begin
        w_grant      = '0;
        w_bankEn     = '0;
        w_bankWe     = '0;
        w_bankRead   = '0;
        w_bankWrSeen = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bankRow[b]    = '0;
            w_bankByteen[b] = '0;
            w_bankWdata[b]  = '0;
        end
        if (r_state == ACCESS) begin
            for (int l = 0; l < LANES; l++) begin
                if (r_pending[l]) begin
                    if (!w_bankEn[w_bank[l]]) begin
                        w_grant[l]                = 1'b1;
                        w_bankEn[w_bank[l]]       = 1'b1;
                        w_bankWe[w_bank[l]]       = r_rw[l];
                        w_bankRead[w_bank[l]]     = !r_rw[l];
                        w_bankRow[w_bank[l]]      = w_row[l];
                        w_bankByteen[w_bank[l]]   = r_byteen[l*DATA_SIZE +: DATA_SIZE];
                        w_bankWdata[w_bank[l]]    = r_data[l*DW +: DW];
                    end else if (BCAST_EN && w_bankRead[w_bank[l]] && !r_rw[l] &&
                                 !w_bankWrSeen[w_bank[l]] && (w_row[l] == w_bankRow[w_bank[l]])) begin
                        w_grant[l] = 1'b1;
                    end
                    if (r_rw[l]) w_bankWrSeen[w_bank[l]] = 1'b1;
                end
            end
        end
    end

    // Bank arrays carry no reset; contents survive an aborted batch.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bankEn[b]) begin
                if (w_bankWe[b]) begin
                    for (int y = 0; y < DATA_SIZE; y++) begin
                        if (w_bankByteen[b][y]) r_mem[b][w_bankRow[b]][y*8 +: 8] <= w_bankWdata[b][y*8 +: 8];
                    end
                end else begin
                    r_bankRdata[b] <= r_mem[b][w_bankRow[b]];
                end
            end
        end
    end

    // ACCESS lingers one cycle after the last grant so the final SRAM read lands in r_result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_tmask    <= '0;
            r_isRead   <= '0;
            r_rw       <= '0;
            r_rdGrant  <= '0;
            r_byteen   <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tag      <= '0;
            r_result   <= '0;
            r_rspValid <= 1'b0;
            r_rspTmask <= '0;
            r_rspData  <= '0;
            r_rspTag   <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (r_rdGrant[l]) r_result[l] <= r_bankRdata[w_bank[l]];
            end
            r_rdGrant <= w_grant & r_isRead;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_pending <= req_valid;
                        r_tmask   <= req_valid;
                        r_isRead  <= req_valid & ~req_rw;
                        r_rw      <= req_rw;
                        r_byteen  <= req_byteen;
                        r_addr    <= req_addr;
                        r_data    <= req_data;
                        r_tag     <= w_firstTag;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_pending <= r_pending & ~w_grant;
                    if (r_pending == '0) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_rspValid <= 1'b1;
                    r_rspTmask <= r_tmask;
                    r_rspTag   <= r_tag;
                    for (int l = 0; l < LANES; l++) begin
                        r_rspData[l*DW +: DW] <= r_isRead[l] ? r_result[l] : '0;
                    end
                    r_state <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_smem_bank_unit.sv
// Randomized scoreboard bench for vx_smem_bank_unit against a lane-ordered memory model.
// Honours SMEM_READ_BCAST_EN when computing expected service cycles.
module tb_vx_smem_bank_unit;

   localparam int LANES = 4;
   localparam int TOTAL_WORDS = 1024;

`ifdef SMEM_READ_BCAST_EN
   localparam bit TB_BCAST = 1'b1;
`else
   localparam bit TB_BCAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_rw = '0;
   logic [15:0]   req_byteen = '0;
   logic [127:0]  req_addr = '0;
   logic [127:0]  req_data = '0;
   logic [31:0]   req_tag = '0;
   logic [3:0]    req_ready;
   logic          rsp_valid;
   logic [3:0]    rsp_tmask;
   logic [127:0]  rsp_data;
   logic [7:0]    rsp_tag;
   logic          rsp_ready = 1'b0;

   typedef struct {
      logic [3:0]   tmask;
      logic [127:0] data;
      logic [7:0]   tag;
      int           acceptCyc;
      int           k;
      int           stall;
   } exp_t;

   exp_t          sb[$];
   logic [31:0]   refMem [TOTAL_WORDS];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   bit            monActive = 1'b0;
   bit            monDrop = 1'b0;

   vx_smem_bank_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_rw     (req_rw),
      .req_byteen (req_byteen),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_tag    (req_tag),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_tmask  (rsp_tmask),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag),
      .rsp_ready  (rsp_ready)
   );

   // Free-running clock and a cycle counter used to measure response latency.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int wordOf(input logic [31:0] a);
      return int'((a >> 2) % TOTAL_WORDS);
   endfunction

   // Per bank, count how many bank slots the lanes need; a read slot absorbs later same-row reads
   // only when broadcast is enabled and no write sits between them.
   function automatic int serviceCycles(input logic [3:0] v, input logic [3:0] rw, input logic [127:0] addr);
      int worst = 0;
      for (int b = 0; b < 4; b++) begin
         int q[$];
         int slots = 0;
         for (int l = 0; l < LANES; l++) begin
            if (v[l] && (wordOf(addr[l*32 +: 32]) % 4) == b) q.push_back(l);
         end
         while (q.size() > 0) begin
            int first = q.pop_front();
            if (!rw[first]) begin
               int keep[$];
               bit blocked = 1'b0;
               foreach (q[i]) begin
                  int j = q[i];
                  if (rw[j]) blocked = 1'b1;
                  if (!(TB_BCAST && !blocked && !rw[j] &&
                        (wordOf(addr[j*32 +: 32]) / 4) == (wordOf(addr[first*32 +: 32]) / 4)))
                     keep.push_back(j);
               end
               q = keep;
            end
            slots++;
         end
         if (slots > worst) worst = slots;
      end
      return worst;
   endfunction

   // Issue one batch, then derive its expected response by applying lanes in order to refMem.
   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] rw, input logic [15:0] be,
                                input logic [127:0] addr, input logic [127:0] data, input logic [31:0] tag,
                                input int stall, input bit doPush);
      int   budget = 0;
      exp_t e;
      while (req_ready !== 4'hF && budget < 300) begin
         @(posedge clk); #1;
         budget++;
      end
      if (req_ready !== 4'hF) begin
         checkOutput("req_ready_wait", {124'd0, req_ready}, 128'hF);
         return;
      end
      req_valid  = v;
      req_rw     = rw;
      req_byteen = be;
      req_addr   = addr;
      req_data   = data;
      req_tag    = tag;
      @(posedge clk); #1;
      req_valid = '0;
      if (v == 4'h0) begin
         checkOutput("idle_no_action", {124'd0, req_ready}, 128'hF);
         return;
      end
      if (!doPush) return;
      e.tmask = v;
      e.data  = '0;
      e.tag   = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (v[l]) e.tag = tag[l*8 +: 8];
      end
      for (int l = 0; l < LANES; l++) begin
         if (v[l]) begin
            int w = wordOf(addr[l*32 +: 32]);
            if (rw[l]) begin
               for (int y = 0; y < 4; y++) begin
                  if (be[l*4 + y]) refMem[w][y*8 +: 8] = data[l*32 + y*8 +: 8];
               end
            end else begin
               e.data[l*32 +: 32] = refMem[w];
            end
         end
      end
      e.acceptCyc = cyc;
      e.k         = serviceCycles(v, rw, addr);
      e.stall     = stall;
      sb.push_back(e);
   endtask

   // Hot pool of words spread over every bank, with random alias bits above the row field.
   function automatic logic [31:0] poolAddr();
      int idx = $urandom_range(0, 20);
      int w = (idx < 17) ? idx : 1003 + idx;
      return ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic randomBatch();
      logic [127:0] addr;
      logic [127:0] data;
      for (int l = 0; l < LANES; l++) begin
         addr[l*32 +: 32] = poolAddr();
         data[l*32 +: 32] = $urandom;
      end
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom),
                    addr, data, $urandom, $urandom_range(0, 3), 1'b1);
   endtask

   // Monitor: pops an expectation when a response appears, holds it for the chosen stall, checks stability.
   initial begin : monitor
      exp_t e;
      int   stallLeft = 0;
      e.tmask = '0; e.data = '0; e.tag = '0; e.acceptCyc = 0; e.k = 0; e.stall = 0;
      forever begin
         @(posedge clk); #1;
         if (monDrop) begin
            checkOutput("rsp_valid_drop", {127'd0, rsp_valid}, 128'd0);
            checkOutput("req_ready_after_hs", {124'd0, req_ready}, 128'hF);
            monDrop   = 1'b0;
            monActive = 1'b0;
            rsp_ready = 1'b0;
         end else if (rsp_valid) begin
            if (!monActive) begin
               monActive = 1'b1;
               if (sb.size() == 0) begin
                  checkOutput("unexpected_rsp", {127'd0, rsp_valid}, 128'd0);
                  stallLeft = 0;
               end else begin
                  e = sb.pop_front();
                  checkOutput("rsp_tmask", {124'd0, rsp_tmask}, {124'd0, e.tmask});
                  checkOutput("rsp_data", rsp_data, e.data);
                  checkOutput("rsp_tag", {120'd0, rsp_tag}, {120'd0, e.tag});
                  checkOutput("latency", 128'(cyc - e.acceptCyc), 128'(e.k + 2));
                  stallLeft = e.stall;
               end
            end else begin
               checkOutput("hold_tmask", {124'd0, rsp_tmask}, {124'd0, e.tmask});
               checkOutput("hold_data", rsp_data, e.data);
               checkOutput("hold_tag", {120'd0, rsp_tag}, {120'd0, e.tag});
               checkOutput("hold_req_ready", {124'd0, req_ready}, 128'd0);
            end
            if (stallLeft == 0) begin
               rsp_ready = 1'b1;
               monDrop   = 1'b1;
            end else begin
               rsp_ready = 1'b0;
               stallLeft--;
            end
         end
      end
   end

   // Directed scenarios first, then a randomized run, then drain and summarize.
   initial begin : main
      int budget;
      #2;
      checkOutput("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
      checkOutput("rst_rsp_tmask", {124'd0, rsp_tmask}, 128'd0);
      checkOutput("rst_rsp_data", rsp_data, 128'd0);
      checkOutput("rst_rsp_tag", {120'd0, rsp_tag}, 128'd0);
      checkOutput("rst_req_ready", {124'd0, req_ready}, 128'd0);
      #20 reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("req_ready_post_rst", {124'd0, req_ready}, 128'hF);

      $display("[TB] directed: full-word writes then reads");
      applyStimulus(4'hF, 4'hF, 16'hFFFF, {32'hC, 32'h8, 32'h4, 32'h0},
                    {32'h44, 32'h33, 32'h22, 32'h11}, 32'h04030201, 0, 1'b1);
      applyStimulus(4'hF, 4'h0, 16'h0000, {32'hC, 32'h8, 32'h4, 32'h0},
                    '0, 32'h08070605, 0, 1'b1);

      $display("[TB] directed: initialise the remaining pool words");
      for (int g = 0; g < 4; g++) begin
         logic [127:0] addr;
         logic [127:0] data;
         for (int l = 0; l < LANES; l++) begin
            int w = (g < 3) ? 4 + g*4 + l : 1020 + l;
            addr[l*32 +: 32] = 32'(w) << 2;
            data[l*32 +: 32] = $urandom;
         end
         applyStimulus(4'hF, 4'hF, 16'hFFFF, addr, data, $urandom, 0, 1'b1);
      end
      applyStimulus(4'h1, 4'h1, 16'h000F, {96'd0, 32'h40}, {96'd0, 32'hCAFE_F00D}, 32'h55, 0, 1'b1);

      $display("[TB] directed: bank conflicts and same-word reads");
      applyStimulus(4'hF, 4'h0, 16'h0, {32'h30, 32'h20, 32'h10, 32'h00}, '0, 32'h0D0C0B0A, 0, 1'b1);
      applyStimulus(4'hF, 4'h0, 16'h0, {32'h40, 32'h40, 32'h40, 32'h40}, '0, 32'h11223344, 0, 1'b1);

      $display("[TB] directed: partial write followed by read of the same word");
      applyStimulus(4'h3, 4'h1, 16'h0003, {32'h0, 32'h0, 32'h8, 32'h8},
                    {32'h0, 32'h0, 32'h0, 32'hAABBCCDD}, 32'h0000_6677, 0, 1'b1);

      $display("[TB] directed: back-pressure on the response");
      applyStimulus(4'h6, 4'h0, 16'h0, {32'h0, 32'hC, 32'h4, 32'h0}, '0, 32'h00EE_DD00, 5, 1'b1);
      applyStimulus(4'h8, 4'h0, 16'h0, {32'hFFC, 32'h0, 32'h0, 32'h0}, '0, 32'h9900_0000, 0, 1'b1);

      $display("[TB] directed: reset during a conflicting batch");
      applyStimulus(4'hF, 4'h0, 16'h0, {32'h30, 32'h20, 32'h10, 32'h00}, '0, 32'h01010101, 0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      checkOutput("abort_rsp_valid", {127'd0, rsp_valid}, 128'd0);
      checkOutput("abort_req_ready_low", {124'd0, req_ready}, 128'd0);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_req_ready", {124'd0, req_ready}, 128'hF);
      repeat (8) @(posedge clk);
      #1;

      $display("[TB] random batches");
      for (int n = 0; n < 60; n++) randomBatch();

      budget = 0;
      while ((sb.size() != 0 || monActive || monDrop) && budget < 1000) begin
         @(posedge clk);
         budget++;
      end
      checkOutput("drain_outstanding", 128'(sb.size()), 128'd0);
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vx_smem_bank_unit.md
Name: vx_smem_bank_unit

Overview:
- Shared-memory storage stage directly downstream of the per-core shared-memory request arbiter.
- Accepts one multi-lane request batch and splits lane addresses across NUM_BANKS single-port SRAM banks.
- Serializes bank conflicts over several cycles, then returns one response carrying a lane mask, per-lane read data and the request tag.
- Its response port feeds the arbiter's per-requester response input.

Parameters:
- LANES, 4, lanes per request batch
- NUM_BANKS, 4, number of banks; power of two
- BANK_WORDS, 256, words per bank; power of two
- DATA_SIZE, 4, bytes per word; power of two
- ADDR_WIDTH, 32, byte address width
- TAG_WIDTH, 8, request/response tag width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  LANES  per-lane request valid
- req_rw  in  LANES  1=write, 0=read
- req_byteen  in  LANES*DATA_SIZE  per-lane byte enables
- req_addr  in  LANES*ADDR_WIDTH  per-lane byte address
- req_data  in  LANES*8*DATA_SIZE  per-lane write data
- req_tag  in  LANES*TAG_WIDTH  per-lane tag
- req_ready  out  LANES  per-lane ready; all bits equal
- rsp_valid  out  1  response valid
- rsp_tmask  out  LANES  lanes serviced
- rsp_data  out  LANES*8*DATA_SIZE  read data per lane
- rsp_tag  out  TAG_WIDTH  response tag
- rsp_ready  in  1  downstream ready

Behaviour:
- Address map: word = addr >> log2(DATA_SIZE); bank = word[log2(NUM_BANKS)-1:0]; row = (word >> log2(NUM_BANKS)) mod BANK_WORDS. Upper bits are ignored, so addresses wrap.
- FSM states: IDLE, ACCESS, DRAIN, RSP.
- Reset (reset=0, asynchronous): state=IDLE; rsp_valid=0, rsp_tmask=0, rsp_data=0, rsp_tag=0; pending mask cleared. Bank contents are not reset.
- Reset mid-operation aborts the batch with no response. Writes already committed stay in the banks.
- req_ready: all bits = (state==IDLE) and reset deasserted. req_ready does not depend on req_valid.
- IDLE to ACCESS, when |req_valid:
  - Registers all lane fields.
  - pending = req_valid; tmask = req_valid.
  - Tag is taken from the lowest-indexed valid lane.
- ACCESS, each cycle, for each bank: grant the lowest-indexed pending lane mapped to that bank.
  - Write: update only the bytes enabled by byteen.
  - Read: issue the read; synchronous SRAM returns data one cycle later into that lane's result register.
  - Clear granted lanes from pending.
  - Number of ACCESS cycles k = maximum number of pending lanes on any single bank.
- ACCESS to DRAIN when pending becomes empty after the grant. DRAIN captures the final read data (one cycle).
- DRAIN to RSP:
  - rsp_valid=1; rsp_tmask=tmask; rsp_tag=captured tag.
  - rsp_data = read result for read lanes, 0 for write lanes and invalid lanes.
- Latency: the accept edge is cycle 0; rsp_valid rises at cycle k+2.
- RSP holds all response outputs stable until rsp_valid && rsp_ready. On that edge go to IDLE and clear rsp_valid. A new batch can be accepted the following cycle.
- Ordering: within a bank, lane order holds. A lower-lane write is visible to a higher-lane read of the same word in the same batch.
- Same bank, same row, two writes: the higher lane is applied later and wins on overlapping bytes.
- All-zero req_valid in IDLE: no action.

Optional Feature:
- Macro: SMEM_READ_BCAST_EN.
- When defined: in ACCESS, pending reads to the same bank and same row as the granted lane are serviced in the same cycle and receive the same data, provided the granted access is a read and no lower pending lane on that bank is a write. k counts distinct rows per bank, adjusted for writes.
- When undefined: strictly one lane per bank per cycle.

Test Plan (LANES=4, NUM_BANKS=4, DATA_SIZE=4):
- Writes all byteen=0xF to 0x0, 0x4, 0x8, 0xC with data 0x11..0x44, then reads of the same addresses:
  - Write batch: k=1, rsp_valid at cycle 3.
  - Read batch: rsp_data = {0x44,0x33,0x22,0x11}, tmask=0xF.
- Reads of 0x00, 0x10, 0x20, 0x30 (all bank 0) -> k=4, rsp_valid at cycle 6, each lane returns its own word.
- All lanes read 0x40:
  - With SMEM_READ_BCAST_EN: rsp at cycle 3.
  - Without it: rsp at cycle 6.
  - Identical data in all lanes either way.
- Lane0 writes 0xAABBCCDD to 0x8 with byteen=0x3; lane1 reads 0x8 (old value 0x22) -> lane1 data 0x0000CCDD; lane0 data 0.
- rsp_ready held low 5 cycles in RSP -> outputs stable, req_ready=0 throughout; accept the next batch the cycle after the handshake.
- reset pulsed low during ACCESS of a conflict batch -> rsp_valid=0 immediately, state IDLE, req_ready=1 after release, no response emitted.
